// File: rtl/adc_receiver.sv
// Controller for a 12-bit CONVST-style SPI ADC: pulses CONVST, waits out the
// conversion, then clocks 12 SCK periods sending a 6-bit config word and capturing the sample.
module adc_receiver #(
    parameter int unsigned CLKS_PER_HALF_SCK = 50,
    parameter int unsigned CONV_WAIT_CLKS    = 80
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_tx_bits,
    input  logic        i_request_conversion,
    output logic        o_rx_dv,
    output logic [11:0] o_rx_data,
    output logic        o_conv_in_process,
    input  logic        i_serial_rx,
    output logic        o_convst,
    output logic        o_sck,
    output logic        o_serial_tx
);

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned CFG_W     = 6;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned CNT_MAX   = (CLKS_PER_HALF_SCK > CONV_WAIT_CLKS) ?
                                        CLKS_PER_HALF_SCK : CONV_WAIT_CLKS;
    localparam int unsigned CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]     HALF_LAST   = CNT_W'(CLKS_PER_HALF_SCK - 1);
    localparam logic [CNT_W-1:0]     WAIT_LAST   = CNT_W'(CONV_WAIT_CLKS - 1);
    localparam logic [CNT_W-1:0]     CONVST_LAST = CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_CONV_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [CFG_W-1:0]     tx_shift_q;
    logic [DATA_W-1:0]    rx_shift_q;
    logic [DATA_W-1:0]    rx_data_q;
    logic                 rx_dv_q;
    logic                 busy_q;
    logic                 convst_q;
    logic                 sck_q;
    logic                 tx_q;

    // Sequencer: every pin and status output comes straight from a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_dv_q    <= 1'b0;
            busy_q     <= 1'b0;
            convst_q   <= 1'b0;
            sck_q      <= 1'b0;
            tx_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_request_conversion) begin
                        tx_shift_q <= i_tx_bits;
                        rx_shift_q <= '0;
                        cnt_q      <= '0;
                        convst_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_CONVST;
                    end
                end
                S_CONVST: begin
                    if (cnt_q == CONVST_LAST) begin
                        cnt_q    <= '0;
                        convst_q <= 1'b0;
                        state_q  <= S_CONV_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CONV_WAIT: begin
                    // Leaving the wait starts the low phase of bit 0, so drive the config MSB now.
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q      <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= tx_shift_q[CFG_W-1];
                        tx_shift_q <= {tx_shift_q[CFG_W-2:0], 1'b0};
                        state_q    <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!sck_q) begin
                            sck_q      <= 1'b1;
                            rx_shift_q <= {rx_shift_q[DATA_W-2:0], i_serial_rx};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_cnt_q == LAST_BIT) begin
                                tx_q      <= 1'b0;
                                rx_data_q <= rx_shift_q;
                                rx_dv_q   <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= S_DONE;
                            end else begin
                                // Config word drains to zeros after six bits.
                                bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
                                tx_q       <= tx_shift_q[CFG_W-1];
                                tx_shift_q <= {tx_shift_q[CFG_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    rx_dv_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rx_dv           = rx_dv_q;
    assign o_rx_data         = rx_data_q;
    assign o_conv_in_process = busy_q;
    assign o_convst          = convst_q;
    assign o_sck             = sck_q;
    assign o_serial_tx       = tx_q;

endmodule

// File: tb/tb_adc_receiver.sv
// Bench for adc_receiver: default-timing and fast-timing instances, each with a
// behavioural ADC that presents its sample MSB first and advances after every SCK rise.
module tb_adc_receiver;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic        a_rst, a_req, a_dv, a_cip, a_miso, a_convst, a_sck, a_mosi;
    logic [5:0]  a_tx;
    logic [11:0] a_data;
    logic [11:0] a_load = '0;
    logic [11:0] a_adc  = '0;

    // Instance B: CLKS_PER_HALF_SCK=3, CONV_WAIT_CLKS=5.
    logic        b_rst, b_req, b_dv, b_cip, b_miso, b_convst, b_sck, b_mosi;
    logic [5:0]  b_tx;
    logic [11:0] b_data;
    logic [11:0] b_load = '0;
    logic [11:0] b_adc  = '0;

    adc_receiver u_dut_a (
        .i_clk               (clk),
        .i_rst               (a_rst),
        .i_tx_bits           (a_tx),
        .i_request_conversion(a_req),
        .o_rx_dv             (a_dv),
        .o_rx_data           (a_data),
        .o_conv_in_process   (a_cip),
        .i_serial_rx         (a_miso),
        .o_convst            (a_convst),
        .o_sck               (a_sck),
        .o_serial_tx         (a_mosi)
    );

    adc_receiver #(
        .CLKS_PER_HALF_SCK(3),
        .CONV_WAIT_CLKS   (5)
    ) u_dut_b (
        .i_clk               (clk),
        .i_rst               (b_rst),
        .i_tx_bits           (b_tx),
        .i_request_conversion(b_req),
        .o_rx_dv             (b_dv),
        .o_rx_data           (b_data),
        .o_conv_in_process   (b_cip),
        .i_serial_rx         (b_miso),
        .o_convst            (b_convst),
        .o_sck               (b_sck),
        .o_serial_tx         (b_mosi)
    );

    // ADC models: load on CONVST rise, next bit after each SCK rise.
    always @(posedge a_convst or posedge a_sck) begin
        if (a_convst) a_adc = a_load;
        else          a_adc = {a_adc[10:0], 1'b0};
    end
    assign a_miso = a_adc[11];

    always @(posedge b_convst or posedge b_sck) begin
        if (b_convst) b_adc = b_load;
        else          b_adc = {b_adc[10:0], 1'b0};
    end
    assign b_miso = b_adc[11];

    // Selected-instance view used by the shared conversion checker.
    logic        sel_b;
    logic        m_convst, m_sck, m_mosi, m_dv, m_cip;
    logic [11:0] m_data;
    assign m_convst = sel_b ? b_convst : a_convst;
    assign m_sck    = sel_b ? b_sck    : a_sck;
    assign m_mosi   = sel_b ? b_mosi   : a_mosi;
    assign m_dv     = sel_b ? b_dv     : a_dv;
    assign m_cip    = sel_b ? b_cip    : a_cip;
    assign m_data   = sel_b ? b_data   : a_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic use_b, input logic v);
        if (use_b) b_req = v;
        else       a_req = v;
    endtask

    // One full conversion, checked cycle by cycle against the expected waveform.
    // t=0 is the first sample with CONVST high; pulse_at<0 means no stray request.
    task automatic run_conv(input string tag, input logic use_b, input logic [5:0] tx,
                            input logic [11:0] word, input logic [11:0] exp_data,
                            input logic [11:0] exp_mosi, input int pulse_at);
        int h, cw, t_sh, t_dv, rises, wave_err, hold_err;
        logic [11:0] mosi_seen, prev_data, data_at_dv;
        logic prev_sck, exp_sck, seen;
        h    = use_b ? 3 : 50;
        cw   = use_b ? 5 : 80;
        t_sh = 2 + cw;
        t_dv = t_sh + 24 * h;
        sel_b = use_b;
        if (use_b) begin b_tx = tx; b_load = word; end
        else       begin a_tx = tx; a_load = word; end
        set_req(use_b, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = m_convst;
        end
        check({tag, "_convst_start"}, 32'(seen), 32'd1);
        set_req(use_b, 1'b0);
        // Config changes after acceptance must not reach MOSI.
        if (use_b) b_tx = ~tx;
        else       a_tx = ~tx;
        check({tag, "_busy_on_accept"}, 32'(m_cip), 32'd1);
        rises = 0; wave_err = 0; hold_err = 0;
        mosi_seen = '0; data_at_dv = '0;
        prev_sck = 1'b0; prev_data = m_data;
        for (int t = 1; t <= t_dv + 1; t++) begin
            @(posedge clk); #1;
            exp_sck = (t >= t_sh) && (t < t_dv) && (((t - t_sh) % (2 * h)) >= h);
            if (m_convst !== (t < 2))      wave_err++;
            if (m_sck !== exp_sck)         wave_err++;
            if (m_cip !== (t < t_dv))      wave_err++;
            if (m_dv !== (t == t_dv))      wave_err++;
            if ((t < t_sh || t >= t_dv) && m_mosi !== 1'b0) wave_err++;
            if (m_sck && !prev_sck) begin
                if (rises < 12) mosi_seen[11 - rises] = m_mosi;
                rises++;
            end
            if (m_dv) data_at_dv = m_data;
            else if (m_data !== prev_data) hold_err++;
            prev_sck  = m_sck;
            prev_data = m_data;
            if (t == pulse_at)     set_req(use_b, 1'b1);
            if (t == pulse_at + 1) set_req(use_b, 1'b0);
        end
        check({tag, "_waveform_errs"}, 32'(wave_err), 32'd0);
        check({tag, "_sck_rises"}, 32'(rises), 32'd12);
        check({tag, "_mosi_at_rises"}, 32'(mosi_seen), 32'(exp_mosi));
        check({tag, "_rx_data"}, 32'(data_at_dv), 32'(exp_data));
        check({tag, "_data_hold_errs"}, 32'(hold_err), 32'd0);
    endtask

    typedef struct {
        logic        use_b;
        logic [5:0]  tx;
        logic [11:0] word;
        logic [11:0] exp_data;
        logic [11:0] exp_mosi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen_i, ndv, nre, gap_err, hold_err, data_err, last_dv, rises;
        logic prev_cv;
        logic [11:0] prev_data;

        vecs[0] = '{1'b0, 6'b100000, 12'hA5C, 12'hA5C, 12'h800};
        vecs[1] = '{1'b0, 6'b101101, 12'h5A3, 12'h5A3, 12'hB40};
        vecs[2] = '{1'b1, 6'b101101, 12'hFFF, 12'hFFF, 12'hB40};
        vecs[3] = '{1'b1, 6'b111111, 12'h000, 12'h000, 12'hFC0};
        vecs[4] = '{1'b1, 6'b010101, 12'hA5C, 12'hA5C, 12'h540};
        vecs[5] = '{1'b1, 6'b100000, 12'h001, 12'h001, 12'h800};

        sel_b = 1'b0;
        a_rst = 1'b1; a_req = 1'b0; a_tx = '0;
        b_rst = 1'b1; b_req = 1'b0; b_tx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a", 32'({a_convst, a_sck, a_mosi, a_dv, a_cip, a_data}), 32'd0);
        check("reset_outputs_b", 32'({b_convst, b_sck, b_mosi, b_dv, b_cip, b_data}), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_no_activity", 32'({a_convst, a_sck, a_mosi, a_cip, b_convst, b_sck, b_mosi, b_cip}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].use_b, vecs[i].tx, vecs[i].word,
                     vecs[i].exp_data, vecs[i].exp_mosi, -10);
            repeat (2) begin @(posedge clk); #1; end
        end

        // Reset asserted for 3 clocks during bit k=4 of the shift phase.
        sel_b = 1'b1;
        b_load = 12'hC33; b_tx = 6'b011110; b_req = 1'b1;
        seen_i = 0;
        for (int i = 0; i < 10 && seen_i == 0; i++) begin
            @(posedge clk); #1;
            if (b_convst) seen_i = 1;
        end
        check("rst_convst_start", 32'(seen_i), 32'd1);
        b_req = 1'b0;
        repeat (32) begin @(posedge clk); #1; end
        check("rst_midshift_busy", 32'(b_cip), 32'd1);
        b_rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_convst", 32'(b_convst), 32'd0);
        check("rst_mid_sck", 32'(b_sck), 32'd0);
        check("rst_mid_mosi", 32'(b_mosi), 32'd0);
        check("rst_mid_busy", 32'(b_cip), 32'd0);
        check("rst_mid_dv", 32'(b_dv), 32'd0);
        check("rst_mid_data", 32'(b_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        ndv = 0; rises = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (b_dv) ndv++;
            if (b_convst || b_sck) rises++;
        end
        check("rst_no_dv_after", 32'(ndv), 32'd0);
        check("rst_no_activity_after", 32'(rises), 32'd0);
        run_conv("post_rst", 1'b1, 6'b001100, 12'h18E, 12'h18E, 12'h300, -10);
        repeat (2) begin @(posedge clk); #1; end

        // Stray request pulse during SHIFT must be dropped.
        run_conv("pulse_in_shift", 1'b1, 6'b110011, 12'h7E1, 12'h7E1, 12'hCC0, 20);
        nre = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b_convst) nre++;
        end
        check("pulse_not_queued", 32'(nre), 32'd0);

        // Request held high: back-to-back conversions, CONVST 2 clocks after each strobe.
        b_load = 12'h3C3; b_tx = 6'b000001; b_req = 1'b1;
        ndv = 0; nre = 0; gap_err = 0; hold_err = 0; data_err = 0;
        last_dv = -1000; prev_cv = 1'b0; prev_data = b_data;
        for (int t = 1; t <= 300; t++) begin
            @(posedge clk); #1;
            if (b_dv) begin
                ndv++;
                last_dv = t;
                if (b_data !== 12'h3C3) data_err++;
            end else if (b_data !== prev_data) begin
                hold_err++;
            end
            if (b_convst && !prev_cv && last_dv > 0) begin
                nre++;
                if (t - last_dv != 2) gap_err++;
            end
            prev_cv = b_convst;
            prev_data = b_data;
        end
        b_req = 1'b0;
        check("held_dv_count", 32'(ndv), 32'd3);
        check("held_rerise_count", 32'(nre), 32'd3);
        check("held_rerise_gap_errs", 32'(gap_err), 32'd0);
        check("held_data_errs", 32'(data_err), 32'd0);
        check("held_data_hold_errs", 32'(hold_err), 32'd0);
        for (int i = 0; i < 200 && b_cip; i++) begin
            @(posedge clk); #1;
        end
        check("held_release_idle", 32'(b_cip), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_receiver.md
Name: adc_receiver

Overview:
- Controller for an SPI-style 12-bit ADC with a CONVST pin and a 6-bit serial configuration word (LTC2308-class).
- On request it pulses CONVST, waits out the conversion time, then runs 12 SCK cycles.
- During those cycles it shifts the 6-bit config word out on MOSI (MSB first) and captures 12 data bits from MISO (MSB first).
- It presents the 12-bit result with a one-clock valid strobe. It sits between system logic and the external ADC pins.

Parameters:
- CLKS_PER_HALF_SCK, default 50: system clocks per SCK half-period. Must be ≥1. At a 50 MHz clock this gives SCK = 500 kHz.
- CONV_WAIT_CLKS, default 80: clocks with CONVST low and SCK idle, after the CONVST pulse and before the first SCK. Must be ≥1.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_tx_bits  in  6  config word sent to ADC; latched when a request is accepted
- i_request_conversion  in  1  level; sampled only in IDLE
- o_rx_dv  out  1  one-clock strobe, o_rx_data valid
- o_rx_data  out  12  last captured sample; held until the next o_rx_dv
- o_conv_in_process  out  1  high while a conversion/readout is in progress
- i_serial_rx  in  1  ADC SDO (MISO)
- o_convst  out  1  ADC CONVST
- o_sck  out  1  ADC SCK, idle low
- o_serial_tx  out  1  ADC SDI (MOSI)

Behaviour:
- Reset:
  - Applies on any edge with i_rst=1, including mid-operation.
  - Goes to IDLE. All outputs are 0 (o_rx_data=0).
  - Shift and counter registers are cleared. Any partial conversion is abandoned with no o_rx_dv.
- All outputs are registered.
- FSM states: IDLE, CONVST, CONV_WAIT, SHIFT, DONE.
- IDLE:
  - If i_request_conversion=1 on an edge: latch i_tx_bits, go to CONVST, and set o_convst=1 and o_conv_in_process=1 on that edge.
  - Otherwise stay in IDLE.
- CONVST:
  - o_convst stays high for exactly 2 clocks.
  - Then o_convst drops and the FSM goes to CONV_WAIT.
- CONV_WAIT: lasts CONV_WAIT_CLKS clocks with o_convst=0 and o_sck=0, then goes to SHIFT.
- SHIFT: 12 bit periods, index k=0..11. Each period is:
  - o_sck low for CLKS_PER_HALF_SCK clocks, then high for CLKS_PER_HALF_SCK clocks.
  - o_serial_tx is updated on the edge that starts the low phase.
  - o_serial_tx = latched bit [5-k] for k<6, and 0 for k≥6.
  - i_serial_rx is sampled on the same edge that drives o_sck high. Samples shift in MSB first, so the first sample ends in bit 11.
- DONE:
  - Entered on the edge that ends the 12th high phase. On that edge: o_sck=0, o_serial_tx=0, o_rx_data=captured word, o_rx_dv=1, o_conv_in_process=0.
  - The next edge clears o_rx_dv and returns to IDLE.
  - Latency: o_rx_dv rises exactly 2 + CONV_WAIT_CLKS + 24*CLKS_PER_HALF_SCK clocks after o_convst rises (1282 with defaults).
- Requests outside IDLE are ignored, not queued. i_tx_bits changes after acceptance have no effect on the current transfer.
- A request held continuously high gives back-to-back conversions. The next o_convst rises 2 clocks after o_rx_dv rises (1 clock in DONE, acceptance in IDLE).
- o_rx_data changes only on the o_rx_dv edge or on reset.

Test Plan:
1. Reset held 3 clocks mid-SHIFT (k=4):
   - All outputs 0 on the next edge and no o_rx_dv afterwards.
   - A new request afterwards starts cleanly from CONVST.
2. Single conversion, defaults, i_tx_bits=6'b100000, ADC model drives 12'hA5C MSB first (changing SDO after each SCK rise):
   - o_convst high 2 clocks.
   - First o_sck rise 80+50 clocks after o_convst falls.
   - o_rx_dv single pulse 1282 clocks after o_convst rose, with o_rx_data=12'hA5C.
   - o_conv_in_process high from request acceptance until that edge.
3. MOSI check, i_tx_bits=6'b101101:
   - At each SCK rise o_serial_tx reads 1,0,1,1,0,1 then 0 for rises 7–12.
   - o_serial_tx=0 while idle.
4. SCK timing, CLKS_PER_HALF_SCK=3, CONV_WAIT_CLKS=5:
   - Exactly 12 o_sck pulses, each 3 high / 3 low.
   - o_rx_dv 2+5+72=79 clocks after o_convst rises.
   - Data 12'hFFF then 12'h001 captured correctly.
5. Request pulsed during SHIFT → ignored, only one o_rx_dv.
   - Request held high continuously → o_convst re-rises 2 clocks after each o_rx_dv rise.
   - o_rx_data holds its value between strobes.
